// File: rtl/mux_arbiter_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
package mux_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      OWN_A = 2'b01,
      OWN_B = 2'b10
   } arb_state_e;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   localparam int unsigned MAX_BURST_LIMIT = 16;
   localparam int unsigned CNT_W           = 5;

endpackage

// File: rtl/mux_arbiter_data_mux.sv
// Combinational WIDTH-bit 2:1 select feeding the arbiter output register.
module arb_data_mux #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             sel_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] y_o
);

   assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter with a single registered output slot.
// Optional per-requester beat counters are enabled by MUX_ARBITER_STATS_EN.
module mux_arbiter
   import mux_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a_valid,
   input  logic [WIDTH-1:0] a_data,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [WIDTH-1:0] b_data,
   output logic             b_ready,
   output logic             sel,
`ifdef MUX_ARBITER_STATS_EN
   output logic [15:0]      grant_cnt_a,
   output logic [15:0]      grant_cnt_b,
`endif
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

   arb_state_e       state_q, state_d;
   logic             sel_q, sel_d;
   logic             prio_q, prio_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [WIDTH-1:0] mux_data;
   logic             can_load, xfer_a, xfer_b;

   assign can_load = !out_valid_q || out_ready;
   assign a_ready  = (state_q == OWN_A) && can_load;
   assign b_ready  = (state_q == OWN_B) && can_load;
   assign xfer_a   = a_valid && a_ready;
   assign xfer_b   = b_valid && b_ready;
   assign cnt_inc  = cnt_q + CNT_W'(1);

   arb_data_mux #(.WIDTH(WIDTH)) u_mux (
      .sel_i (sel_q),
      .a_i   (a_data),
      .b_i   (b_data),
      .y_o   (mux_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sel_q       <= SEL_A;
         prio_q      <= SEL_A;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         prio_q      <= prio_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   // Ownership FSM: burst limit only forces a handover when the other side waits
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      prio_d      = prio_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;

      unique case (state_q)
         IDLE: begin
            if (a_valid && b_valid) begin
               state_d = (prio_q == SEL_B) ? OWN_B : OWN_A;
               sel_d   = prio_q;
            end else if (a_valid) begin
               state_d = OWN_A;
               sel_d   = SEL_A;
            end else if (b_valid) begin
               state_d = OWN_B;
               sel_d   = SEL_B;
            end
         end
         OWN_A: begin
            if (!a_valid) begin
               prio_d = SEL_B;
               cnt_d  = '0;
               if (b_valid) begin
                  state_d = OWN_B;
                  sel_d   = SEL_B;
               end else begin
                  state_d = IDLE;
               end
            end else if (can_load) begin
               if ((cnt_inc >= MAX_CNT) && b_valid) begin
                  state_d = OWN_B;
                  sel_d   = SEL_B;
                  prio_d  = SEL_B;
                  cnt_d   = '0;
               end else begin
                  cnt_d = (cnt_inc >= MAX_CNT) ? MAX_CNT : cnt_inc;
               end
            end
         end
         OWN_B: begin
            if (!b_valid) begin
               prio_d = SEL_A;
               cnt_d  = '0;
               if (a_valid) begin
                  state_d = OWN_A;
                  sel_d   = SEL_A;
               end else begin
                  state_d = IDLE;
               end
            end else if (can_load) begin
               if ((cnt_inc >= MAX_CNT) && a_valid) begin
                  state_d = OWN_A;
                  sel_d   = SEL_A;
                  prio_d  = SEL_A;
                  cnt_d   = '0;
               end else begin
                  cnt_d = (cnt_inc >= MAX_CNT) ? MAX_CNT : cnt_inc;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (xfer_a || xfer_b) begin
         out_valid_d = 1'b1;
         out_data_d  = mux_data;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   assign sel       = sel_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

`ifdef MUX_ARBITER_STATS_EN
   logic [15:0] grant_cnt_a_q, grant_cnt_b_q;

   // Accepted-beat counters, wrapping naturally at 16 bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt_a_q <= '0;
         grant_cnt_b_q <= '0;
      end else begin
         if (xfer_a) grant_cnt_a_q <= grant_cnt_a_q + 16'd1;
         if (xfer_b) grant_cnt_b_q <= grant_cnt_b_q + 16'd1;
      end
   end

   assign grant_cnt_a = grant_cnt_a_q;
   assign grant_cnt_b = grant_cnt_b_q;
`endif

endmodule

// File: tb/tb_mux_arbiter.sv
// Scoreboard bench for mux_arbiter: expected beat order is queued by each test
// and compared as the output slot drains.
module tb_mux_arbiter;

   localparam int unsigned WIDTH     = 4;
   localparam int unsigned MAX_BURST = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             a_valid, b_valid, a_ready, b_ready;
   logic [WIDTH-1:0] a_data, b_data, out_data;
   logic             sel, out_valid, out_ready;
`ifdef MUX_ARBITER_STATS_EN
   logic [15:0]      grant_cnt_a, grant_cnt_b;
`endif

   mux_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .a_valid     (a_valid),
      .a_data      (a_data),
      .a_ready     (a_ready),
      .b_valid     (b_valid),
      .b_data      (b_data),
      .b_ready     (b_ready),
      .sel         (sel),
`ifdef MUX_ARBITER_STATS_EN
      .grant_cnt_a (grant_cnt_a),
      .grant_cnt_b (grant_cnt_b),
`endif
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [WIDTH-1:0] qa[$];
   logic [WIDTH-1:0] qb[$];
   logic [WIDTH-1:0] sb[$];

   int first_drain, last_drain, last_acc_a, first_acc_b, b_rdy_seen;

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0; out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Drive queued beats cycle by cycle; out_ready low for [stall_from, stall_from+stall_len)
   task automatic run(input int budget, input int stall_from, input int stall_len,
                      input bit final_chk);
      int cyc;
      logic acc_a, acc_b, held_v;
      logic [WIDTH-1:0] held, exp;
      cyc = 0; held_v = 1'b0; held = '0;
      first_drain = -1; last_drain = -1; last_acc_a = -1; first_acc_b = -1; b_rdy_seen = 0;
      while (cyc < budget && (sb.size() > 0 || qa.size() > 0 || qb.size() > 0)) begin
         a_valid   = (qa.size() > 0);
         a_data    = a_valid ? qa[0] : '0;
         b_valid   = (qb.size() > 0);
         b_data    = b_valid ? qb[0] : '0;
         out_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
         #1;
         acc_a = a_valid && a_ready;
         acc_b = b_valid && b_ready;
         if (b_ready) b_rdy_seen++;
         if (acc_a) begin
            checks++;
            if (sel !== 1'b0) begin
               failures++; $display("FAIL sel_on_a cyc=%0d got=%b exp=0", cyc, sel);
            end
            last_acc_a = cyc;
         end
         if (acc_b) begin
            checks++;
            if (sel !== 1'b1) begin
               failures++; $display("FAIL sel_on_b cyc=%0d got=%b exp=1", cyc, sel);
            end
            if (first_acc_b < 0) first_acc_b = cyc;
         end
         if (held_v) begin
            checks++;
            if (out_data !== held) begin
               failures++; $display("FAIL hold_data cyc=%0d got=%h exp=%h", cyc, out_data, held);
            end
         end
         if (out_valid === 1'b1 && !out_ready) begin
            checks++;
            if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
               failures++;
               $display("FAIL stall_ready cyc=%0d got a=%b b=%b exp 0 0", cyc, a_ready, b_ready);
            end
         end
         held_v = (out_valid === 1'b1) && !out_ready;
         held   = out_data;
         if (out_valid === 1'b1 && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               failures++; $display("FAIL extra_beat cyc=%0d got=%h exp=none", cyc, out_data);
            end else begin
               exp = sb.pop_front();
               if (out_data !== exp) begin
                  failures++; $display("FAIL beat cyc=%0d got=%h exp=%h", cyc, out_data, exp);
               end
            end
            if (first_drain < 0) first_drain = cyc;
            last_drain = cyc;
         end
         @(posedge clk);
         if (acc_a) void'(qa.pop_front());
         if (acc_b) void'(qb.pop_front());
         @(negedge clk);
         cyc++;
      end
      if (final_chk) begin
         a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
         #1;
         checks++;
         if (sb.size() != 0 || qa.size() != 0 || qb.size() != 0) begin
            failures++;
            $display("FAIL timeout pending sb=%0d qa=%0d qb=%0d exp 0 0 0", sb.size(), qa.size(), qb.size());
         end
         checks++;
         if (out_valid !== 1'b0) begin
            failures++; $display("FAIL trailing_beat got out_valid=%b exp=0", out_valid);
         end
         sb.delete(); qa.delete(); qb.delete();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      a_valid = 1'b1; b_valid = 1'b1; a_data = 4'h3; b_data = 4'h7; out_ready = 1'b1;
      #3;
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || sel !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_state got v=%b d=%h sel=%b ar=%b br=%b exp 0 0 0 0 0",
                  out_valid, out_data, sel, a_ready, b_ready);
      end
      do_reset();
   endtask

   task automatic test_a_stream();
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         qa.push_back(WIDTH'(i)); sb.push_back(WIDTH'(i));
      end
      run(40, 1000, 0, 1'b1);
      checks++;
      if (first_drain != 2 || last_drain != 6) begin
         failures++;
         $display("FAIL a_latency got first=%0d last=%0d exp 2 6", first_drain, last_drain);
      end
      checks++;
      if (b_rdy_seen != 0) begin
         failures++; $display("FAIL b_ready_idle got=%0d cycles exp=0", b_rdy_seen);
      end
   endtask

   task automatic test_contention();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         qa.push_back(WIDTH'(i)); qb.push_back(WIDTH'(i + 8));
      end
      for (int i = 0; i < 4; i++) sb.push_back(WIDTH'(i));
      for (int i = 8; i < 12; i++) sb.push_back(WIDTH'(i));
      for (int i = 4; i < 8; i++) sb.push_back(WIDTH'(i));
      for (int i = 12; i < 16; i++) sb.push_back(WIDTH'(i));
      run(60, 1000, 0, 1'b1);
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int i = 1; i <= 6; i++) begin
         qa.push_back(WIDTH'(i)); sb.push_back(WIDTH'(i));
      end
      run(40, 3, 3, 1'b1);
      checks++;
      if (first_drain != 2 || last_drain != 10) begin
         failures++;
         $display("FAIL bp_timing got first=%0d last=%0d exp 2 10", first_drain, last_drain);
      end
   endtask

   task automatic test_early_release();
      do_reset();
      qa.push_back(4'h1); qa.push_back(4'h2);
      qb.push_back(4'h9); qb.push_back(4'hA); qb.push_back(4'hB);
      sb.push_back(4'h1); sb.push_back(4'h2);
      sb.push_back(4'h9); sb.push_back(4'hA); sb.push_back(4'hB);
      run(40, 1000, 0, 1'b1);
      checks++;
      if (first_acc_b - last_acc_a != 2) begin
         failures++;
         $display("FAIL handover_gap got=%0d exp=2", first_acc_b - last_acc_a);
      end
      // Priority now points at A
      qa.push_back(4'h3); qb.push_back(4'hC);
      sb.push_back(4'h3); sb.push_back(4'hC);
      run(40, 1000, 0, 1'b1);
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         qb.push_back(WIDTH'(i + 8)); sb.push_back(WIDTH'(i + 8));
      end
      run(3, 1000, 0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || sel !== 1'b1) begin
         failures++; $display("FAIL pre_reset got v=%b sel=%b exp 1 1", out_valid, sel);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || sel !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
         failures++;
         $display("FAIL async_reset got v=%b sel=%b ar=%b br=%b exp 0 0 0 0",
                  out_valid, sel, a_ready, b_ready);
      end
      qa.delete(); qb.delete(); sb.delete();
      a_valid = 1'b0; b_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      qa.push_back(4'h5); qb.push_back(4'hD);
      sb.push_back(4'h5); sb.push_back(4'hD);
      run(40, 1000, 0, 1'b1);
   endtask

`ifdef MUX_ARBITER_STATS_EN
   task automatic test_stats();
      do_reset();
      #1;
      checks++;
      if (grant_cnt_a !== 16'd0 || grant_cnt_b !== 16'd0) begin
         failures++; $display("FAIL stats_reset got a=%0d b=%0d exp 0 0", grant_cnt_a, grant_cnt_b);
      end
      for (int i = 0; i < 10; i++) begin
         qa.push_back(WIDTH'(i)); sb.push_back(WIDTH'(i));
      end
      run(60, 1000, 0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         qb.push_back(WIDTH'(15 - i)); sb.push_back(WIDTH'(15 - i));
      end
      run(60, 1000, 0, 1'b1);
      checks++;
      if (grant_cnt_a !== 16'd10 || grant_cnt_b !== 16'd6) begin
         failures++; $display("FAIL stats_count got a=%0d b=%0d exp 10 6", grant_cnt_a, grant_cnt_b);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_a_stream();
      test_contention();
      test_backpressure();
      test_early_release();
      test_reset_mid_burst();
`ifdef MUX_ARBITER_STATS_EN
      test_stats();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
